div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider serving the execute stage. EX is the initiator: it presents operands and holds `start_i` while the pipeline is stalled. `div_unit` is the responder: it runs a radix-2 restoring division and returns a 64-bit `{remainder, quotient}` with `ready_o`. It sits beside the EX stage and is fed by the operands that the ID/EX register delivers.

## Interface
- `DATA_W`, default 32: operand width. Only 32 is supported; the result is `2*DATA_W` wide.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start_i`  in  1  divide request from EX; held high until `ready_o` is seen.
- `annul_i`  in  1  abort request; a flush kills the in-flight divide.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `result_o`  out  64  `{remainder[31:0], quotient[31:0]}`.
- `ready_o`  out  1  result valid.

## Operation
- States: FREE, BYZERO, ON, END. On reset: state FREE, `result_o`=0, `ready_o`=0, iteration counter=0.
- FREE
  - `start_i`=1 and `annul_i`=0 and `opdata2_i`=0: go to BYZERO.
  - `start_i`=1 and `annul_i`=0 and `opdata2_i`≠0: go to ON.
    - Latch the operand magnitudes. When signed, use the two's-complement absolute value of each negative operand.
    - Latch the sign flags and clear the counter.
  - Otherwise stay in FREE.
- BYZERO: unconditionally go to END with the result forced to 0.
- ON
  - `annul_i`=1: go to FREE. `ready_o` stays 0 and no result is produced.
  - Counter < 32: perform one restoring step, then increment the counter.
    - Shift the 65-bit working register left by 1.
    - Subtract the divisor from the upper 33 bits.
    - If the difference is non-negative, keep it and set quotient bit 1. Otherwise restore and set quotient bit 0.
  - Counter = 32: apply sign correction, register the result, go to END.
- Sign correction (signed only):
  - Quotient is negated when the operand signs differ.
  - Remainder is negated when the dividend is negative.
- END
  - `ready_o`=1 and `result_o` holds the value.
  - When `start_i`=0: go to FREE with `result_o`=0 and `ready_o`=0.
  - While `start_i` stays 1: hold.
  - `annul_i` has no effect in END.
- Overflow case (signed 0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. Wrap-around is natural; there is no trap.
- Operand changes after the start sample are ignored until the unit returns to FREE.

## Timing
- Edge E0 samples `start_i` in FREE.
- Nonzero divisor:
  - Iterations occur on E1–E32.
  - E33 registers the result; `ready_o` is high after E33, i.e. 34 edges including E0.
- Zero divisor: E0 enters BYZERO and E1 enters END, so `ready_o` is high after 2 edges.
- Release: EX drops `start_i` in the first cycle it sees `ready_o`=1. `ready_o` falls after the next edge. A new `start_i` is accepted no earlier than the edge after that.
- `rst`=0 at any edge overrides everything, including mid-ON and END: FREE, with zeroed outputs on the following cycle.
- `annul_i` and `start_i` both high in FREE: the start is not taken.

## Configuration
- `DIV_SIGNED_EN` defined:
  - `signed_div_i` is honoured; magnitude conversion and sign correction logic are built.
- Not defined:
  - `signed_div_i` is ignored and every divide is unsigned.
  - The magnitude/negation logic is compiled out.
  - Latency is unchanged.

## Test plan
- Unsigned 100 / 7 (`signed_div_i`=0) → after 34 edges `ready_o`=1, `result_o`=0x00000002_0000000E. Drop `start_i` → next cycle `ready_o`=0, `result_o`=0.
- Signed 0xFFFFFFF9 / 2 (−7/2) with `DIV_SIGNED_EN` → `result_o`=0xFFFFFFFF_FFFFFFFD (rem −1, quot −3).
- 5 / 0 → `ready_o`=1 after 2 edges, `result_o`=0. Holding `start_i` high 5 more cycles keeps `ready_o`=1.
- Start 1000 / 3, pulse `annul_i` at E10 → state FREE and `ready_o` never asserts. Then start 9 / 3 → after 34 edges `result_o`=0x00000000_00000003.
- Signed 0x80000000 / 0xFFFFFFFF → `result_o`=0x00000000_80000000. Same operands built without `DIV_SIGNED_EN` → `result_o`=0x80000000_00000000.
- `rst`=0 at E15 of a divide → next cycle `ready_o`=0, `result_o`=0. A fresh 100 / 7 then completes in 34 edges.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider beside the EX stage.
// Define DIV_SIGNED_EN to build signed (DIV) support; default is unsigned only.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*DATA_W:0]   work_q, work_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [2*DATA_W:0]   shifted;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   mag1, mag2;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;
    logic neg1, neg2;

    assign neg1     = signed_div_i & opdata1_i[DATA_W-1];
    assign neg2     = signed_div_i & opdata2_i[DATA_W-1];
    assign mag1     = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
    assign mag2     = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
    assign quot_fix = neg_quot_q ? (~work_q[DATA_W-1:0] + 1'b1)
                                 : work_q[DATA_W-1:0];
    assign rem_fix  = neg_rem_q ? (~work_q[2*DATA_W-1:DATA_W] + 1'b1)
                                : work_q[2*DATA_W-1:DATA_W];
`else
    logic unused_sign;

    assign unused_sign = signed_div_i;
    assign mag1        = opdata1_i;
    assign mag2        = opdata2_i;
    assign quot_fix    = work_q[DATA_W-1:0];
    assign rem_fix     = work_q[2*DATA_W-1:DATA_W];
`endif

    // Top bit of work_q is always zero after a step, so the shift drops nothing.
    assign shifted = {work_q[2*DATA_W-1:0], 1'b0};
    assign diff    = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        ready_d   = ready_q;
`ifdef DIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        unique case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d   = ON;
                        work_d    = {{(DATA_W+1){1'b0}}, mag1};
                        divisor_d = mag2;
                        cnt_d     = '0;
`ifdef DIV_SIGNED_EN
                        neg_quot_d = neg1 ^ neg2;
                        neg_rem_d  = neg1;
`endif
                    end
                end
            end
            BYZERO: begin
                state_d  = END;
                result_d = '0;
                ready_d  = 1'b1;
            end
            ON: begin
                if (annul_i) begin
                    state_d = FREE;
                end else if (cnt_q != CW'(DATA_W)) begin
                    if (diff[DATA_W]) begin
                        work_d = {shifted[2*DATA_W:1], 1'b0};
                    end else begin
                        work_d = {diff, shifted[DATA_W-1:1], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                    state_d  = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed vector bench for div_unit: results, latency, zero divide,
// annul, reset mid-divide and in END, operand changes after start.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_SIGNED_EN
    localparam logic [63:0] EXP_N7_2   = 64'hFFFFFFFF_FFFFFFFD;
    localparam logic [63:0] EXP_OVF    = 64'h00000000_80000000;
    localparam logic [63:0] EXP_7_N2   = 64'h00000001_FFFFFFFD;
    localparam logic [63:0] EXP_N100N7 = 64'hFFFFFFFE_0000000E;
`else
    localparam logic [63:0] EXP_N7_2   = 64'h00000001_7FFFFFFC;
    localparam logic [63:0] EXP_OVF    = 64'h80000000_00000000;
    localparam logic [63:0] EXP_7_N2   = 64'h00000007_00000000;
    localparam logic [63:0] EXP_N100N7 = 64'hFFFFFF9C_00000000;
`endif

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string nm, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int lat,
                           input int hold);
        int n;
        n = 0;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 1) begin
                opdata1_i    = 32'hA5A5_5A5A;
                opdata2_i    = 32'h0;
                signed_div_i = ~sgn;
            end
            if (ready_o) begin
                n = i;
                break;
            end
        end
        chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " result"}, result_o, exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({nm, " hold ready"}, 64'(ready_o), 64'd1);
            chk({nm, " hold result"}, result_o, exp);
        end
        start_i = 1'b0;
        tick();
        chk({nm, " release ready"}, 64'(ready_o), 64'd0);
        chk({nm, " release result"}, result_o, 64'd0);
    endtask

    initial begin
        int seen;

        tbl[0]  = '{1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 0};
        tbl[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2, EXP_N7_2, 34, 0};
        tbl[2]  = '{1'b0, 32'd5, 32'd0, 64'd0, 2, 5};
        tbl[3]  = '{1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 0};
        tbl[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, EXP_OVF, 34, 0};
        tbl[5]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF,
                    64'h80000000_00000000, 34, 0};
        tbl[6]  = '{1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34, 0};
        tbl[7]  = '{1'b0, 32'd7, 32'd100, 64'h00000007_00000000, 34, 0};
        tbl[8]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 34, 2};
        tbl[9]  = '{1'b0, 32'hDEADBEEF, 32'h10, 64'h0000000F_0DEADBEE, 34, 0};
        tbl[10] = '{1'b1, 32'd7, 32'hFFFFFFFE, EXP_7_N2, 34, 0};
        tbl[11] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, EXP_N100N7, 34, 0};

        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) tick();
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        rst = 1'b1;
        tick();

        for (int k = 0; k < 12; k++) begin
            run_div($sformatf("vec%0d", k), tbl[k].sgn, tbl[k].a, tbl[k].b,
                    tbl[k].exp, tbl[k].lat, tbl[k].hold);
        end

        // start together with annul in FREE must not launch a divide
        annul_i   = 1'b1;
        start_i   = 1'b1;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        repeat (3) tick();
        annul_i = 1'b0;
        run_div("annul_free", 1'b0, 32'd100, 32'd7,
                64'h00000002_0000000E, 34, 0);

        // annul sampled at E10 kills the divide
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (10) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) seen++;
        end
        chk("annul no ready", 64'(seen), 64'd0);
        chk("annul result", result_o, 64'd0);
        run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'd3, 34, 0);

        // reset sampled at E15 of a divide
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (15) tick();
        rst = 1'b0;
        tick();
        chk("rst mid ready", 64'(ready_o), 64'd0);
        chk("rst mid result", result_o, 64'd0);
        rst = 1'b1;
        start_i = 1'b0;
        tick();
        run_div("after_rst", 1'b0, 32'd100, 32'd7,
                64'h00000002_0000000E, 34, 0);

        // reset while holding a result in END
        start_i = 1'b1;
        seen    = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ready_o) begin
                seen = 1;
                break;
            end
        end
        chk("end reached", 64'(seen), 64'd1);
        rst = 1'b0;
        tick();
        chk("rst end ready", 64'(ready_o), 64'd0);
        chk("rst end result", result_o, 64'd0);
        rst     = 1'b1;
        start_i = 1'b0;
        tick();
        run_div("after_rst_end", 1'b0, 32'd100, 32'd7,
                64'h00000002_0000000E, 34, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
